// File: rtl/dmem_copy_engine.sv
// dmem_copy_engine
// ----------------
// Block-move initiator for the 256-entry data memory. Given a source address,
// a destination address and a word count, it streams whole RNS words (all
// domains together, no conversion) from source to destination. The direction
// of the copy is chosen so that overlapping ranges behave like memmove,
// including ranges that wrap past address 0xFF.
//
// Ports:
//   clk              system clock
//   reset            synchronous, active-high reset
//   start            1-cycle copy request, only looked at while idle
//   src_addr         first source word address
//   dst_addr         first destination word address
//   length           number of words to copy, 0..256
//   mem_grant        memory ports belong to the engine this cycle
//   dmem_dout        read data, combinational on data_rd_addr
//   data_rd_addr     registered read address
//   data_wr_addr     registered write address
//   datamem_wr_data  registered write data
//   store_to_mem     registered write strobe (memory writes at the closing edge)
//   busy             copy in progress
//   done             1-cycle completion pulse
//   words_done       writes issued for the current/last copy
module dmem_copy_engine #(
  parameter int NUM_DOMAINS = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [7:0]               src_addr,
  input  logic [7:0]               dst_addr,
  input  logic [8:0]               length,
  input  logic                     mem_grant,
  input  logic [NUM_DOMAINS*8-1:0] dmem_dout,
  output logic [7:0]               data_rd_addr,
  output logic [7:0]               data_wr_addr,
  output logic [NUM_DOMAINS*8-1:0] datamem_wr_data,
  output logic                     store_to_mem,
  output logic                     busy,
  output logic                     done,
  output logic [8:0]               words_done
);

  localparam int DW = NUM_DOMAINS * 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state, state_n;
  logic [8:0]    remaining, remaining_n;
  logic [7:0]    rd_ptr, rd_ptr_n;
  logic [7:0]    wr_ptr, wr_ptr_n;
  logic          desc, desc_n;
  logic [7:0]    wr_addr_q, wr_addr_n;
  logic [DW-1:0] wr_data_q, wr_data_n;
  logic          store_q, store_n;
  logic [8:0]    words_q, words_n;

  logic [7:0]    delta;
  logic          start_desc;
  logic [7:0]    ptr_step;

  // Distance from source to destination, mod 256. If the destination lies
  // inside the source run (ahead of it), an ascending copy would overwrite
  // words before reading them, so the copy runs from the top down instead.
  assign delta      = dst_addr - src_addr;
  assign start_desc = (delta != 8'd0) && ({1'b0, delta} < length);
  assign ptr_step   = desc ? 8'hFF : 8'h01;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      remaining <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      desc      <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      store_q   <= 1'b0;
      words_q   <= '0;
    end else begin
      state     <= state_n;
      remaining <= remaining_n;
      rd_ptr    <= rd_ptr_n;
      wr_ptr    <= wr_ptr_n;
      desc      <= desc_n;
      wr_addr_q <= wr_addr_n;
      wr_data_q <= wr_data_n;
      store_q   <= store_n;
      words_q   <= words_n;
    end
  end

  // Next-state and datapath updates. A word is read in one cycle (address
  // already on data_rd_addr) and its write is strobed in the following cycle,
  // so the final RUN cycle with nothing left to capture still carries the
  // last write strobe; the strobe is dropped on leaving RUN.
  always_comb begin
    state_n     = state;
    remaining_n = remaining;
    rd_ptr_n    = rd_ptr;
    wr_ptr_n    = wr_ptr;
    desc_n      = desc;
    wr_addr_n   = wr_addr_q;
    wr_data_n   = wr_data_q;
    store_n     = 1'b0;
    words_n     = words_q;

    case (state)
      IDLE: begin
        if (start) begin
          words_n = '0;
          if (length == 9'd0) begin
            state_n = DONE;
          end else begin
            state_n     = RUN;
            remaining_n = length;
            desc_n      = start_desc;
            if (start_desc) begin
              rd_ptr_n = src_addr + length[7:0] - 8'd1;
              wr_ptr_n = dst_addr + length[7:0] - 8'd1;
            end else begin
              rd_ptr_n = src_addr;
              wr_ptr_n = dst_addr;
            end
          end
        end
      end

      RUN: begin
        if (remaining == 9'd0) begin
          state_n = DRAIN;
        end else if (mem_grant) begin
          wr_data_n   = dmem_dout;
          wr_addr_n   = wr_ptr;
          store_n     = 1'b1;
          words_n     = words_q + 9'd1;
          rd_ptr_n    = rd_ptr + ptr_step;
          wr_ptr_n    = wr_ptr + ptr_step;
          remaining_n = remaining - 9'd1;
        end
      end

      DRAIN: begin
        state_n = DONE;
      end

      DONE: begin
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign data_rd_addr    = rd_ptr;
  assign data_wr_addr    = wr_addr_q;
  assign datamem_wr_data = wr_data_q;
  assign store_to_mem    = store_q;
  assign words_done      = words_q;
  assign busy            = (state == RUN) || (state == DRAIN);
  assign done            = (state == DONE);

endmodule

// File: tb/tb_dmem_copy_engine.sv
// tb_dmem_copy_engine
// -------------------
// Directed bench for dmem_copy_engine with NUM_DOMAINS=2. A behavioural
// 256x16 memory sits on the engine's ports; each scenario preloads it, runs
// one copy cycle by cycle and compares memory contents, strobe counts and
// completion timing against hand-computed values.
module tb_dmem_copy_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  src_addr;
  logic [7:0]  dst_addr;
  logic [8:0]  length;
  logic        mem_grant;
  logic [15:0] dmem_dout;
  logic [7:0]  data_rd_addr;
  logic [7:0]  data_wr_addr;
  logic [15:0] datamem_wr_data;
  logic        store_to_mem;
  logic        busy;
  logic        done;
  logic [8:0]  words_done;

  logic [15:0] mem [256];

  int checks = 0;
  int passes = 0;

  int          store_cnt;
  int          stall_store_cnt;
  int          done_cyc;
  int          done_cnt;
  logic [7:0]  first_wr_addr;
  logic        post_rst_store;
  logic        post_rst_busy;

  dmem_copy_engine #(.NUM_DOMAINS(2)) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .src_addr        (src_addr),
    .dst_addr        (dst_addr),
    .length          (length),
    .mem_grant       (mem_grant),
    .dmem_dout       (dmem_dout),
    .data_rd_addr    (data_rd_addr),
    .data_wr_addr    (data_wr_addr),
    .datamem_wr_data (datamem_wr_data),
    .store_to_mem    (store_to_mem),
    .busy            (busy),
    .done            (done),
    .words_done      (words_done)
  );

  always #5 clk = ~clk;

  // Memory model: combinational read, write at the edge closing a strobe cycle.
  assign dmem_dout = mem[data_rd_addr];

  always @(posedge clk) begin
    if (store_to_mem) mem[data_wr_addr] <= datamem_wr_data;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
  endtask

  // Runs one copy. Cycle 0 is the cycle with start high; cycle k begins after
  // the k-th following posedge. Grant is low for cycles stall_lo..stall_hi,
  // start is re-pulsed in cycle poke_cyc and reset is high in cycle rst_cyc.
  task automatic applyStimulus(input logic [7:0] s, input logic [7:0] d,
                               input logic [8:0] n, input int stall_lo,
                               input int stall_hi, input int poke_cyc,
                               input int rst_cyc, input int max_cyc);
    logic got_first;
    got_first       = 1'b0;
    store_cnt       = 0;
    stall_store_cnt = 0;
    done_cyc        = -1;
    done_cnt        = 0;
    first_wr_addr   = 8'h00;
    post_rst_store  = 1'b1;
    post_rst_busy   = 1'b1;
    @(posedge clk); #1;
    src_addr  = s;
    dst_addr  = d;
    length    = n;
    start     = 1'b1;
    mem_grant = 1'b1;
    for (int cyc = 1; cyc <= max_cyc; cyc++) begin
      @(posedge clk); #1;
      start     = (cyc == poke_cyc);
      mem_grant = !(cyc >= stall_lo && cyc <= stall_hi);
      reset     = (cyc == rst_cyc);
      @(negedge clk);
      if (store_to_mem) begin
        store_cnt++;
        if (!got_first) first_wr_addr = data_wr_addr;
        got_first = 1'b1;
        if (cyc > stall_lo && cyc <= stall_hi + 1) stall_store_cnt++;
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (cyc == rst_cyc + 1) begin
        post_rst_store = store_to_mem;
        post_rst_busy  = busy;
      end
    end
    start     = 1'b0;
    reset     = 1'b0;
    mem_grant = 1'b1;
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    src_addr  = 8'h00;
    dst_addr  = 8'h00;
    length    = 9'd0;
    mem_grant = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 16'(i) ^ 16'h5A00;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_store", 32'(store_to_mem), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_words", 32'(words_done), 32'd0);
    checkOutput("rst_addrs", {16'h0, data_rd_addr, data_wr_addr}, 32'd0);
    checkOutput("rst_wdata", 32'(datamem_wr_data), 32'd0);
    reset = 1'b0;

    // Non-overlapping copy.
    mem[8'h10] = 16'd11; mem[8'h11] = 16'd22; mem[8'h12] = 16'd33; mem[8'h13] = 16'd44;
    applyStimulus(8'h10, 8'h80, 9'd4, -10, -10, -1, -1, 10);
    checkOutput("nov_m80", 32'(mem[8'h80]), 32'd11);
    checkOutput("nov_m81", 32'(mem[8'h81]), 32'd22);
    checkOutput("nov_m82", 32'(mem[8'h82]), 32'd33);
    checkOutput("nov_m83", 32'(mem[8'h83]), 32'd44);
    checkOutput("nov_stores", 32'(store_cnt), 32'd4);
    checkOutput("nov_done_cyc", 32'(done_cyc), 32'd7);
    checkOutput("nov_words", 32'(words_done), 32'd4);

    // Zero-length request.
    applyStimulus(8'h10, 8'h90, 9'd0, -10, -10, -1, -1, 4);
    checkOutput("len0_done_cyc", 32'(done_cyc), 32'd1);
    checkOutput("len0_stores", 32'(store_cnt), 32'd0);
    checkOutput("len0_words", 32'(words_done), 32'd0);

    // Forward overlap: destination below source, ascending.
    for (int i = 0; i < 5; i++) mem[8'h20 + i] = 16'(i + 1);
    applyStimulus(8'h21, 8'h20, 9'd4, -10, -10, -1, -1, 10);
    checkOutput("fwd_m20", 32'(mem[8'h20]), 32'd2);
    checkOutput("fwd_m21", 32'(mem[8'h21]), 32'd3);
    checkOutput("fwd_m22", 32'(mem[8'h22]), 32'd4);
    checkOutput("fwd_m23", 32'(mem[8'h23]), 32'd5);
    checkOutput("fwd_m24", 32'(mem[8'h24]), 32'd5);
    checkOutput("fwd_first_wr", 32'(first_wr_addr), 32'h20);

    // Backward overlap: destination above source, descending.
    for (int i = 0; i < 5; i++) mem[8'h20 + i] = (i < 4) ? 16'(i + 1) : 16'hBEEF;
    applyStimulus(8'h20, 8'h21, 9'd4, -10, -10, -1, -1, 10);
    checkOutput("bwd_m20", 32'(mem[8'h20]), 32'd1);
    checkOutput("bwd_m21", 32'(mem[8'h21]), 32'd1);
    checkOutput("bwd_m22", 32'(mem[8'h22]), 32'd2);
    checkOutput("bwd_m23", 32'(mem[8'h23]), 32'd3);
    checkOutput("bwd_m24", 32'(mem[8'h24]), 32'd4);
    checkOutput("bwd_first_wr", 32'(first_wr_addr), 32'h24);
    checkOutput("bwd_done_cyc", 32'(done_cyc), 32'd7);

    // Source wraps past 0xFF, grant withdrawn for cycles 3-4.
    mem[8'hFE] = 16'h0102; mem[8'hFF] = 16'h0304; mem[8'h00] = 16'h0506; mem[8'h01] = 16'h0708;
    applyStimulus(8'hFE, 8'h40, 9'd4, 3, 4, -1, -1, 12);
    checkOutput("wrap_m40", 32'(mem[8'h40]), 32'h0102);
    checkOutput("wrap_m41", 32'(mem[8'h41]), 32'h0304);
    checkOutput("wrap_m42", 32'(mem[8'h42]), 32'h0506);
    checkOutput("wrap_m43", 32'(mem[8'h43]), 32'h0708);
    checkOutput("wrap_stores", 32'(store_cnt), 32'd4);
    checkOutput("wrap_stall_stores", 32'(stall_store_cnt), 32'd0);
    checkOutput("wrap_done_cyc", 32'(done_cyc), 32'd9);

    // Full 256-word identity copy with a start pulse while busy.
    for (int i = 0; i < 256; i++) mem[i] = 16'(i) + 16'h1100;
    applyStimulus(8'h00, 8'h00, 9'd256, -10, -10, 10, -1, 262);
    checkOutput("full_stores", 32'(store_cnt), 32'd256);
    checkOutput("full_words", 32'(words_done), 32'd256);
    checkOutput("full_done_cyc", 32'(done_cyc), 32'd259);
    checkOutput("full_done_cnt", 32'(done_cnt), 32'd1);
    checkOutput("full_m00", 32'(mem[8'h00]), 32'h1100);
    checkOutput("full_mFF", 32'(mem[8'hFF]), 32'h11FF);

    // Reset during cycle 4 of an 8-word copy.
    for (int i = 0; i < 8; i++) begin
      mem[8'h60 + i] = 16'hA0 + 16'(i);
      mem[8'h90 + i] = 16'hEEEE;
    end
    applyStimulus(8'h60, 8'h90, 9'd8, -10, -10, -1, 4, 14);
    checkOutput("rmid_post_store", 32'(post_rst_store), 32'd0);
    checkOutput("rmid_post_busy", 32'(post_rst_busy), 32'd0);
    checkOutput("rmid_done_cnt", 32'(done_cnt), 32'd0);
    checkOutput("rmid_stores", 32'(store_cnt), 32'd3);
    checkOutput("rmid_m90", 32'(mem[8'h90]), 32'hA0);
    checkOutput("rmid_m92", 32'(mem[8'h92]), 32'hA2);
    checkOutput("rmid_m93", 32'(mem[8'h93]), 32'hEEEE);
    checkOutput("rmid_words", 32'(words_done), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
